// File: rtl/iter_divider_pkg.sv
// Shared types and constants for the iterative RV64M divider.
// Op encodings mirror the ALU-side DivSel decode.
package iter_divider_pkg;

    localparam int XLEN  = 64;
    localparam int CNT_W = 7;

    localparam logic [1:0] DIV_DIV  = 2'b00;
    localparam logic [1:0] DIV_DIVU = 2'b01;
    localparam logic [1:0] DIV_REM  = 2'b10;
    localparam logic [1:0] DIV_REMU = 2'b11;

    localparam logic [CNT_W-1:0] N_DW = 7'd64;
    localparam logic [CNT_W-1:0] N_W  = 7'd32;

    localparam logic [XLEN-1:0] MIN_D = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0] MIN_W = {{(XLEN-31){1'b1}}, {31{1'b0}}};

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUSY,
        ST_DONE
    } div_state_e;

    function automatic logic [XLEN-1:0] sext_word(input logic [XLEN-1:0] v);
        return {{(XLEN-32){v[31]}}, v[31:0]};
    endfunction

    function automatic logic [XLEN-1:0] zext_word(input logic [XLEN-1:0] v);
        return {{(XLEN-32){1'b0}}, v[31:0]};
    endfunction

endpackage

// File: rtl/iter_divider_if.sv
// Request/response handshake between the execute stage and the divider.
interface iter_divider_if;
    import iter_divider_pkg::*;

    logic            in_valid;
    logic            in_ready;
    logic [1:0]      div_op;
    logic            is_word;
    logic [XLEN-1:0] src1;
    logic [XLEN-1:0] src2;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] result;

    modport master (
        output in_valid, div_op, is_word, src1, src2, out_ready,
        input  in_ready, out_valid, result
    );

    modport slave (
        input  in_valid, div_op, is_word, src1, src2, out_ready,
        output in_ready, out_valid, result
    );

endinterface

// File: rtl/iter_divider_div_step.sv
// One radix-2 restoring step: shift in the next dividend bit and trial-subtract.
module div_step
    import iter_divider_pkg::*;
(
    input  logic [XLEN-1:0] rem_i,
    input  logic            msb_i,
    input  logic [XLEN-1:0] divisor_i,
    output logic [XLEN-1:0] rem_o,
    output logic            q_o
);
    // One extra bit: the shifted remainder can reach 2*divisor-1.
    logic [XLEN:0] shifted;
    logic [XLEN:0] trial;

    always_comb begin
        shifted = {rem_i, msb_i};
        trial   = shifted - {1'b0, divisor_i};
        q_o     = ~trial[XLEN];
        rem_o   = q_o ? trial[XLEN-1:0] : shifted[XLEN-1:0];
    end

endmodule

// File: rtl/iter_divider.sv
// Multi-cycle restoring divider for DIV/DIVU/REM/REMU and their W forms.
//   state | meaning
//   IDLE  | in_ready=1, waiting for an op
//   BUSY  | one quotient bit per cycle, counter counts down from N
//   DONE  | out_valid=1, result held until out_ready
module iter_divider
    import iter_divider_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    iter_divider_if.slave dif
);
    div_state_e       state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [XLEN-1:0]  rem_q;
    logic [XLEN-1:0]  dvd_q;
    logic [XLEN-1:0]  dvs_q;
    logic [XLEN-1:0]  result_q;
    logic             neg_q;
    logic             rem_sel_q;
    logic             word_q;
    logic             in_ready_q;
    logic             out_valid_q;

    logic             is_signed;
    logic             rem_sel;
    logic [XLEN-1:0]  a_ext;
    logic [XLEN-1:0]  b_ext;
    logic [XLEN-1:0]  a_abs;
    logic [XLEN-1:0]  b_abs;
    logic             a_neg;
    logic             b_neg;
    logic             div_zero;
    logic             overflow;
    logic [XLEN-1:0]  special_res;

    always_comb begin
        is_signed = (dif.div_op == DIV_DIV) || (dif.div_op == DIV_REM);
        rem_sel   = (dif.div_op == DIV_REM) || (dif.div_op == DIV_REMU);
        if (dif.is_word) begin
            a_ext = is_signed ? sext_word(dif.src1) : zext_word(dif.src1);
            b_ext = is_signed ? sext_word(dif.src2) : zext_word(dif.src2);
        end else begin
            a_ext = dif.src1;
            b_ext = dif.src2;
        end
        a_neg    = is_signed & a_ext[XLEN-1];
        b_neg    = is_signed & b_ext[XLEN-1];
        a_abs    = a_neg ? -a_ext : a_ext;
        b_abs    = b_neg ? -b_ext : b_ext;
        div_zero = (b_ext == '0);
        overflow = is_signed && (b_ext == '1) &&
                   (a_ext == (dif.is_word ? MIN_W : MIN_D));
        if (div_zero) begin
            special_res = rem_sel ? a_ext : '1;
        end else begin
            special_res = rem_sel ? '0 : a_ext;
        end
        if (dif.is_word) begin
            special_res = sext_word(special_res);
        end
    end

    logic [XLEN-1:0] rem_d;
    logic [XLEN-1:0] dvd_d;
    logic            q_bit;
    logic [XLEN-1:0] raw_res;
    logic [XLEN-1:0] signed_res;
    logic [XLEN-1:0] final_res;

    div_step u_step (
        .rem_i     (rem_q),
        .msb_i     (dvd_q[XLEN-1]),
        .divisor_i (dvs_q),
        .rem_o     (rem_d),
        .q_o       (q_bit)
    );

    // The dividend register doubles as the quotient shift register.
    always_comb begin
        dvd_d      = {dvd_q[XLEN-2:0], q_bit};
        raw_res    = rem_sel_q ? rem_d : dvd_d;
        signed_res = neg_q ? -raw_res : raw_res;
        final_res  = word_q ? sext_word(signed_res) : signed_res;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            rem_q       <= '0;
            dvd_q       <= '0;
            dvs_q       <= '0;
            result_q    <= '0;
            neg_q       <= 1'b0;
            rem_sel_q   <= 1'b0;
            word_q      <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else if (flush) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (dif.in_valid) begin
                        rem_q      <= '0;
                        // W forms start with the 32-bit dividend at the top so 32 steps suffice.
                        dvd_q      <= dif.is_word ? {a_abs[31:0], {(XLEN-32){1'b0}}} : a_abs;
                        dvs_q      <= b_abs;
                        neg_q      <= rem_sel ? a_neg : (a_neg ^ b_neg);
                        rem_sel_q  <= rem_sel;
                        word_q     <= dif.is_word;
                        in_ready_q <= 1'b0;
                        if (div_zero || overflow) begin
                            result_q    <= special_res;
                            out_valid_q <= 1'b1;
                            state_q     <= ST_DONE;
                        end else begin
                            cnt_q   <= dif.is_word ? N_W : N_DW;
                            state_q <= ST_BUSY;
                        end
                    end
                end
                ST_BUSY: begin
                    rem_q <= rem_d;
                    dvd_q <= dvd_d;
                    cnt_q <= cnt_q - 1'b1;
                    if (cnt_q == 7'd1) begin
                        result_q    <= final_res;
                        out_valid_q <= 1'b1;
                        state_q     <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (dif.out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= ST_IDLE;
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign dif.in_ready  = in_ready_q;
    assign dif.out_valid = out_valid_q;
    assign dif.result    = result_q;

endmodule

// File: tb/tb_iter_divider.sv
// Directed bench for iter_divider: results, latency, handshake hold, flush and reset.
module tb_iter_divider;
    import iter_divider_pkg::*;

    logic clk;
    logic rst_n;
    logic flush;
    int   n_checks;
    int   n_errors;

    iter_divider_if dif ();

    iter_divider dut (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .dif   (dif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic drive_op(input logic [1:0] op, input logic w,
                            input logic [63:0] a, input logic [63:0] b);
        @(negedge clk);
        dif.div_op   = op;
        dif.is_word  = w;
        dif.src1     = a;
        dif.src2     = b;
        dif.in_valid = 1'b1;
        @(posedge clk);
        #1;
        dif.in_valid = 1'b0;
    endtask

    // Latency counts edges from the accepting edge until out_valid is seen.
    task automatic wait_result(output int lat);
        lat = 1;
        while (!dif.out_valid && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic run_op(input string tag, input logic [1:0] op, input logic w,
                          input logic [63:0] a, input logic [63:0] b,
                          input logic [63:0] exp_res, input int exp_lat);
        int lat;
        drive_op(op, w, a, b);
        wait_result(lat);
        check({tag, "_lat"}, 64'(lat), 64'(exp_lat));
        check(tag, dif.result, exp_res);
        @(posedge clk);
        #1;
        check({tag, "_back_idle"}, {63'b0, dif.in_ready}, 64'd1);
    endtask

    initial begin
        int lat;
        int seen;
        n_checks      = 0;
        n_errors      = 0;
        rst_n         = 1'b0;
        flush         = 1'b0;
        dif.in_valid  = 1'b0;
        dif.div_op    = DIV_DIV;
        dif.is_word   = 1'b0;
        dif.src1      = '0;
        dif.src2      = '0;
        dif.out_ready = 1'b1;

        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", {63'b0, dif.in_ready}, 64'd1);
        check("rst_out_valid", {63'b0, dif.out_valid}, 64'd0);
        check("rst_result", dif.result, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op("divu_100_7", DIV_DIVU, 1'b0, 64'd100, 64'd7, 64'd14, 65);
        run_op("remu_100_7", DIV_REMU, 1'b0, 64'd100, 64'd7, 64'd2, 65);
        run_op("rem_m7_2", DIV_REM, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2,
               64'hFFFF_FFFF_FFFF_FFFF, 65);
        run_op("div_m7_2", DIV_DIV, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2,
               64'hFFFF_FFFF_FFFF_FFFD, 65);
        run_op("div_100_m7", DIV_DIV, 1'b0, 64'd100, 64'hFFFF_FFFF_FFFF_FFF9,
               64'hFFFF_FFFF_FFFF_FFF2, 65);
        run_op("rem_100_m7", DIV_REM, 1'b0, 64'd100, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 65);
        run_op("divu_big", DIV_DIVU, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0001,
               64'd1, 65);
        run_op("remu_big", DIV_REMU, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0001,
               64'h7FFF_FFFF_FFFF_FFFE, 65);
        run_op("divu_2p32", DIV_DIVU, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1_0000_0000,
               64'h0000_0000_FFFF_FFFF, 65);
        run_op("div_by0", DIV_DIV, 1'b0, 64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1);
        run_op("remu_by0", DIV_REMU, 1'b0, 64'd5, 64'd0, 64'd5, 1);
        run_op("div_ovf", DIV_DIV, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
               64'h8000_0000_0000_0000, 1);
        run_op("rem_ovf", DIV_REM, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
               64'd0, 1);
        run_op("divw_ovf", DIV_DIV, 1'b1, 64'h1234_5678_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
               64'hFFFF_FFFF_8000_0000, 1);
        run_op("divuw_fffe_1", DIV_DIVU, 1'b1, 64'h0000_0000_FFFF_FFFE, 64'd1,
               64'hFFFF_FFFF_FFFF_FFFE, 33);
        run_op("divuw_hi_junk", DIV_DIVU, 1'b1, 64'hDEAD_BEEF_0000_0064, 64'hABCD_0000_0000_0007,
               64'd14, 33);
        run_op("remw_m7_2", DIV_REM, 1'b1, 64'h0000_ABCD_FFFF_FFF9, 64'd2,
               64'hFFFF_FFFF_FFFF_FFFF, 33);
        run_op("remuw_by0", DIV_REMU, 1'b1, 64'h0000_0001_8000_0005, 64'hFFFF_FFFF_0000_0000,
               64'hFFFF_FFFF_8000_0005, 1);

        // Result held in DONE while out_ready is low; a new request must be ignored.
        dif.out_ready = 1'b0;
        drive_op(DIV_DIVU, 1'b0, 64'd100, 64'd7);
        wait_result(lat);
        check("hold_lat", 64'(lat), 64'd65);
        @(negedge clk);
        dif.div_op   = DIV_REMU;
        dif.src1     = 64'd999;
        dif.src2     = 64'd0;
        dif.in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            check("hold_result", dif.result, 64'd14);
            check("hold_in_ready", {63'b0, dif.in_ready}, 64'd0);
            check("hold_out_valid", {63'b0, dif.out_valid}, 64'd1);
        end
        @(negedge clk);
        dif.in_valid  = 1'b0;
        dif.out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("hold_release_valid", {63'b0, dif.out_valid}, 64'd0);
        check("hold_release_ready", {63'b0, dif.in_ready}, 64'd1);

        // Flush in BUSY cycle 20.
        drive_op(DIV_DIVU, 1'b0, 64'd100, 64'd7);
        repeat (19) @(posedge clk);
        #1;
        check("flush_busy_pre", {63'b0, dif.in_ready}, 64'd0);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        check("flush_busy_ready", {63'b0, dif.in_ready}, 64'd1);
        check("flush_busy_valid", {63'b0, dif.out_valid}, 64'd0);
        seen = 0;
        repeat (80) begin
            @(posedge clk);
            #1;
            if (dif.out_valid) seen = 1;
        end
        check("flush_busy_no_result", 64'(seen), 64'd0);

        // Flush beats a simultaneous accept.
        @(negedge clk);
        dif.div_op   = DIV_DIV;
        dif.is_word  = 1'b0;
        dif.src1     = 64'd5;
        dif.src2     = 64'd0;
        dif.in_valid = 1'b1;
        flush        = 1'b1;
        @(posedge clk);
        #1;
        dif.in_valid = 1'b0;
        flush        = 1'b0;
        check("flush_accept_ready", {63'b0, dif.in_ready}, 64'd1);
        check("flush_accept_valid", {63'b0, dif.out_valid}, 64'd0);
        @(posedge clk);
        #1;
        check("flush_accept_valid2", {63'b0, dif.out_valid}, 64'd0);

        // Flush in DONE, together with out_ready.
        dif.out_ready = 1'b0;
        drive_op(DIV_DIV, 1'b0, 64'd5, 64'd0);
        check("flush_done_pre", {63'b0, dif.out_valid}, 64'd1);
        @(negedge clk);
        flush         = 1'b1;
        dif.out_ready = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        check("flush_done_valid", {63'b0, dif.out_valid}, 64'd0);
        check("flush_done_ready", {63'b0, dif.in_ready}, 64'd1);

        // Reset mid-BUSY; result register still holds the all-ones value from before.
        drive_op(DIV_DIVU, 1'b0, 64'd100, 64'd7);
        repeat (10) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("rst_busy_ready", {63'b0, dif.in_ready}, 64'd1);
        check("rst_busy_valid", {63'b0, dif.out_valid}, 64'd0);
        check("rst_busy_result", dif.result, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen  = 0;
        repeat (80) begin
            @(posedge clk);
            #1;
            if (dif.out_valid) seen = 1;
        end
        check("rst_busy_no_result", 64'(seen), 64'd0);

        run_op("recover_div", DIV_DIV, 1'b0, 64'd100, 64'hFFFF_FFFF_FFFF_FFF9,
               64'hFFFF_FFFF_FFFF_FFF2, 65);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
